fetch_exc_pipe: RTL and testbench

FETCH_EXC_PIPE -- requirements
Module: fetch_exc_pipe

---
 rtl/fetch_exc_pipe.sv | 118 +++++++++++
 tb/tb_fetch_exc_pipe.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_exc_pipe.sv
// IF/ID stage register with fetch-address exception detection.
// A bad fetch address (outside the text window or misaligned) is latched into
// ID as AdEL. Fetch is then suppressed until CP0 acknowledges it. After the
// acknowledge there is one extra drain cycle, and then normal loading resumes.
module fetch_exc_pipe #(
    parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
    parameter logic [31:0] TEXT_LIMIT = 32'h0000_4FFF,
    parameter int          ALIGN_BITS = 2,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      pc_if,
    input  logic             if_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             exc_ack,
    output logic             valid_id,
    output logic [4:0]       exccode_id,
    output logic [31:0]      badvaddr_id,
    output logic             exc_pending,
    output logic [CNT_W-1:0] exc_count
);

    localparam logic [4:0] ADEL = 5'b00100;
    localparam logic [4:0] NEXC = 5'b11111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_misalign;
    logic             w_err;
    logic             w_take;
    logic             w_suppress;
    logic             r_valid;
    logic [4:0]       r_code;
    logic [31:0]      r_bad;
    logic [CNT_W-1:0] r_cnt;

    // The alignment term vanishes when no low bits are checked.
    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign w_misalign = |pc_if[ALIGN_BITS-1:0];
        end else begin : g_noalign
            assign w_misalign = 1'b0;
        end
    endgenerate

    assign w_err = (pc_if < TEXT_BASE) | (pc_if > TEXT_LIMIT) | w_misalign;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic: flush always returns to IDLE; an exception is only raised by a real load
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (!stall && if_valid && w_err) w_state_nxt = PEND;
                PEND:    if (exc_ack) w_state_nxt = DRAIN;
                DRAIN:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: pending flag, fetch suppression, exception-taken strobe
    always_comb begin
        exc_pending = (r_state != IDLE);
        w_suppress  = (r_state != IDLE);
        w_take      = (r_state == IDLE) && (w_state_nxt == PEND);
    end

    // IF/ID stage registers: flush > stall > suppression > load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_code  <= NEXC;
            r_bad   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_code  <= NEXC;
            r_bad   <= '0;
        end else if (stall) begin
            r_valid <= r_valid;
        end else if (w_suppress) begin
            r_valid <= 1'b0;
            r_code  <= NEXC;
            r_bad   <= '0;
        end else begin
            r_valid <= if_valid;
            r_code  <= (if_valid && w_err) ? ADEL : NEXC;
            r_bad   <= (if_valid && w_err) ? pc_if : 32'h0;
        end
    end

    // Saturating count of exceptions taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 r_cnt <= '0;
        else if (w_take && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end

    assign valid_id    = r_valid;
    assign exccode_id  = r_code;
    assign badvaddr_id = r_bad;
    assign exc_count   = r_cnt;

endmodule

// File: tb/tb_fetch_exc_pipe.sv
// Bench for fetch_exc_pipe: a vector table walked through a scoreboard, plus
// hand-written reset sequences. A second instance with a 2-bit counter shares
// the stimulus so that counter saturation can be observed.
module tb_fetch_exc_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_if;
    logic        if_valid, stall, flush, exc_ack;
    logic        valid_id, exc_pending;
    logic [4:0]  exccode_id;
    logic [31:0] badvaddr_id;
    logic [7:0]  exc_count;
    logic        v2, p2;
    logic [4:0]  c2;
    logic [31:0] b2;
    logic [1:0]  cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_exc_pipe dut (
        .clk(clk), .reset_n(reset_n), .pc_if(pc_if), .if_valid(if_valid),
        .stall(stall), .flush(flush), .exc_ack(exc_ack),
        .valid_id(valid_id), .exccode_id(exccode_id), .badvaddr_id(badvaddr_id),
        .exc_pending(exc_pending), .exc_count(exc_count)
    );

    fetch_exc_pipe #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .pc_if(pc_if), .if_valid(if_valid),
        .stall(stall), .flush(flush), .exc_ack(exc_ack),
        .valid_id(v2), .exccode_id(c2), .badvaddr_id(b2),
        .exc_pending(p2), .exc_count(cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        v, st, fl, ack;
        logic        ev;
        logic [4:0]  ecode;
        logic [31:0] ebad;
        logic        ep;
        logic [7:0]  ecnt;
        logic [1:0]  ecnt2;
    } vec_t;

    typedef struct {
        int          id;
        logic        ev;
        logic [4:0]  ecode;
        logic [31:0] ebad;
        logic        ep;
        logic [7:0]  ecnt;
        logic [1:0]  ecnt2;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic [31:0] pc, input logic v, st, fl, ack,
                                input logic ev, input logic [4:0] ecode,
                                input logic [31:0] ebad, input logic ep,
                                input logic [7:0] ecnt);
        vec_t t;
        t.pc = pc; t.v = v; t.st = st; t.fl = fl; t.ack = ack;
        t.ev = ev; t.ecode = ecode; t.ebad = ebad; t.ep = ep; t.ecnt = ecnt;
        t.ecnt2 = (ecnt > 8'd3) ? 2'd3 : ecnt[1:0];
        return t;
    endfunction

    task automatic check(input exp_t e);
        n_cmp++;
        if (valid_id !== e.ev || exccode_id !== e.ecode || badvaddr_id !== e.ebad ||
            exc_pending !== e.ep || exc_count !== e.ecnt || cnt2 !== e.ecnt2) begin
            n_bad++;
            $display("FAIL step%0d: got v=%b code=%h bad=%h pend=%b cnt=%0d cnt2=%0d, want v=%b code=%h bad=%h pend=%b cnt=%0d cnt2=%0d",
                     e.id, valid_id, exccode_id, badvaddr_id, exc_pending, exc_count, cnt2,
                     e.ev, e.ecode, e.ebad, e.ep, e.ecnt, e.ecnt2);
        end
    endtask

    task automatic check_reset(input string name);
        n_cmp++;
        if (valid_id !== 1'b0 || exccode_id !== 5'h1F || badvaddr_id !== 32'h0 ||
            exc_pending !== 1'b0 || exc_count !== 8'd0 ||
            v2 !== 1'b0 || c2 !== 5'h1F || b2 !== 32'h0 || p2 !== 1'b0 || cnt2 !== 2'd0) begin
            n_bad++;
            $display("FAIL %s: got v=%b code=%h bad=%h pend=%b cnt=%0d cnt2=%0d, want reset values 0/1f/0/0/0/0",
                     name, valid_id, exccode_id, badvaddr_id, exc_pending, exc_count, cnt2);
        end
    endtask

    // Drive one vector just after an edge, then compare just after the next edge.
    task automatic step(input vec_t t, input int id);
        exp_t e;
        pc_if = t.pc; if_valid = t.v; stall = t.st; flush = t.fl; exc_ack = t.ack;
        e.id = id; e.ev = t.ev; e.ecode = t.ecode; e.ebad = t.ebad;
        e.ep = t.ep; e.ecnt = t.ecnt; e.ecnt2 = t.ecnt2;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        check(e);
    endtask

    initial begin
        //           pc          v  st fl ak   ev code   bad          ep cnt
        vt.push_back(mk(32'h3000, 1, 0, 0, 0,  1, 5'h1F, 32'h0,       0, 0));
        vt.push_back(mk(32'h4FFC, 1, 0, 0, 0,  1, 5'h1F, 32'h0,       0, 0));
        vt.push_back(mk(32'h3004, 0, 0, 0, 0,  0, 5'h1F, 32'h0,       0, 0));
        vt.push_back(mk(32'h5000, 0, 0, 0, 0,  0, 5'h1F, 32'h0,       0, 0));
        vt.push_back(mk(32'h5000, 1, 0, 0, 0,  1, 5'h04, 32'h5000,    1, 1));
        vt.push_back(mk(32'h3000, 1, 0, 0, 0,  0, 5'h1F, 32'h0,       1, 1));
        vt.push_back(mk(32'h3000, 1, 0, 0, 0,  0, 5'h1F, 32'h0,       1, 1));
        vt.push_back(mk(32'h3000, 1, 0, 0, 1,  0, 5'h1F, 32'h0,       1, 1));
        vt.push_back(mk(32'h3000, 1, 0, 0, 1,  0, 5'h1F, 32'h0,       0, 1));
        vt.push_back(mk(32'h3004, 1, 0, 0, 0,  1, 5'h1F, 32'h0,       0, 1));
        vt.push_back(mk(32'h3002, 1, 0, 0, 0,  1, 5'h04, 32'h3002,    1, 2));
        vt.push_back(mk(32'h3004, 1, 0, 0, 1,  0, 5'h1F, 32'h0,       1, 2));
        vt.push_back(mk(32'h3004, 1, 0, 0, 0,  0, 5'h1F, 32'h0,       0, 2));
        vt.push_back(mk(32'h3004, 1, 0, 0, 0,  1, 5'h1F, 32'h0,       0, 2));
        vt.push_back(mk(32'h3000, 1, 0, 0, 1,  1, 5'h1F, 32'h0,       0, 2));
        vt.push_back(mk(32'h2FFC, 1, 1, 0, 0,  1, 5'h1F, 32'h0,       0, 2));
        vt.push_back(mk(32'h2FFC, 1, 1, 0, 0,  1, 5'h1F, 32'h0,       0, 2));
        vt.push_back(mk(32'h2FFC, 1, 0, 0, 0,  1, 5'h04, 32'h2FFC,    1, 3));
        vt.push_back(mk(32'h3000, 1, 0, 1, 1,  0, 5'h1F, 32'h0,       0, 3));
        vt.push_back(mk(32'h5000, 1, 0, 1, 0,  0, 5'h1F, 32'h0,       0, 3));
        vt.push_back(mk(32'h4FFF, 1, 0, 0, 0,  1, 5'h04, 32'h4FFF,    1, 4));
        vt.push_back(mk(32'h3000, 1, 1, 0, 1,  1, 5'h04, 32'h4FFF,    1, 4));
        vt.push_back(mk(32'h3000, 1, 1, 0, 0,  1, 5'h04, 32'h4FFF,    0, 4));
        vt.push_back(mk(32'h3000, 1, 0, 0, 0,  1, 5'h1F, 32'h0,       0, 4));
        vt.push_back(mk(32'h2FFC, 1, 0, 0, 0,  1, 5'h04, 32'h2FFC,    1, 5));
        vt.push_back(mk(32'h3000, 1, 1, 1, 0,  0, 5'h1F, 32'h0,       0, 5));
        vt.push_back(mk(32'h5000, 1, 0, 0, 0,  1, 5'h04, 32'h5000,    1, 6));
        vt.push_back(mk(32'h3000, 1, 1, 0, 0,  1, 5'h04, 32'h5000,    1, 6));
        vt.push_back(mk(32'h3000, 1, 0, 0, 0,  0, 5'h1F, 32'h0,       1, 6));
        vt.push_back(mk(32'h3000, 1, 0, 0, 1,  0, 5'h1F, 32'h0,       1, 6));
        vt.push_back(mk(32'h3000, 1, 0, 0, 0,  0, 5'h1F, 32'h0,       0, 6));

        pc_if = 32'h0; if_valid = 0; stall = 0; flush = 0; exc_ack = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 check_reset("reset_initial");
        @(posedge clk); @(posedge clk); #1;
        check_reset("reset_held");
        reset_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) step(vt[i], i);

        // Reset in the middle of a pending exception: outputs clear without a clock edge.
        step(mk(32'h5000, 1, 0, 0, 0, 1, 5'h04, 32'h5000, 1, 7), 100);
        step(mk(32'h3000, 1, 0, 0, 0, 0, 5'h1F, 32'h0, 1, 7), 101);
        #2 reset_n = 1'b0;
        #1 check_reset("reset_mid_pend_async");
        @(posedge clk); #1;
        check_reset("reset_mid_pend_held");
        reset_n = 1'b1;
        // First edge after release performs a normal load, from a zero count.
        step(mk(32'h3000, 1, 0, 0, 0, 1, 5'h1F, 32'h0, 0, 0), 102);
        step(mk(32'h4FFC, 1, 0, 0, 0, 1, 5'h1F, 32'h0, 0, 0), 103);
        step(mk(32'h5000, 1, 0, 0, 0, 1, 5'h04, 32'h5000, 1, 1), 104);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
